serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor: the next generation of the team's one-bit half-adder primitive.
- Processes one bit per clock, LSB first, using a single sum/carry cell and a registered carry.
- Sits in the adder library for area-constrained datapaths where WIDTH-cycle latency is acceptable.
- Adds a start/busy/done handshake, an add/subtract mode, a carry-out flag and a signed-overflow flag.

---
 rtl/serial_addsub.sv | 125 ++++++++++++
 tb/tb_serial_addsub.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor built around one sum/carry cell.
// Operands are shifted out LSB first, one bit per clock. The sum bits shift
// into S from the MSB side, so S holds the aligned result after WIDTH cycles.
// Subtraction is A + ~B + 1: B is inverted at load time and the carry is
// seeded with MODE.
//
// Handshake: START is accepted on a rising edge only in IDLE or FIN (when
// BUSY=0). BUSY is high for the WIDTH cycles that follow acceptance.
// DONE pulses for one cycle, and S/COUT/OVF are valid from that cycle
// until the next accepted operation starts shifting.
// START during RUN is ignored.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_nx;
  logic             busy_nx;
  logic             done_nx;

  assign dbg_state = state;

  // Serial cell: one full-adder slice plus the accept/last-bit decodes.
  always_comb begin
    accept   = START && ((state == IDLE) || (state == FIN));
    last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
    sum_bit  = ra[0] ^ rb[0] ^ carry;
    carry_nx = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
  end

  // State register; reset has priority over START.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_bit) state_nx = FIN;
      FIN:     state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the next state, so BUSY/DONE can be registered.
  always_comb begin
    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == FIN);
  end

  // Registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      BUSY <= busy_nx;
      DONE <= done_nx;
    end
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle,
  // and capture the flags on the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else if (accept) begin
      ra    <= A;
      rb    <= MODE ? ~B : B;
      carry <= MODE;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= {1'b0, ra[WIDTH-1:1]};
      rb    <= {1'b0, rb[WIDTH-1:1]};
      carry <= carry_nx;
      S     <= {sum_bit, S[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        COUT <= carry_nx;
        // On the MSB slice, carry is the carry into the MSB and carry_nx is
        // the carry out of it; their XOR is the signed-overflow flag.
        OVF  <= carry ^ carry_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed handshake and arithmetic cases on a
// WIDTH=8 instance, then random operations on WIDTH=2, 8 and 33 instances.
module tb_serial_addsub;

  logic        CLK;
  logic        rst;
  logic        start_v [3];
  logic        mode_v  [3];
  logic [63:0] a_v     [3];
  logic [63:0] b_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        cout_v  [3];
  logic        ovf_v   [3];
  logic [1:0]  st_v    [3];
  logic [7:0]  s0;
  logic [1:0]  s1;
  logic [32:0] s2;

  logic [65:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  serial_addsub #(.WIDTH(8)) u_w8 (
    .CLK(CLK), .RST(rst), .START(start_v[0]), .MODE(mode_v[0]),
    .A(a_v[0][7:0]), .B(b_v[0][7:0]), .BUSY(busy_v[0]), .DONE(done_v[0]),
    .S(s0), .COUT(cout_v[0]), .OVF(ovf_v[0]), .dbg_state(st_v[0])
  );

  serial_addsub #(.WIDTH(2)) u_w2 (
    .CLK(CLK), .RST(rst), .START(start_v[1]), .MODE(mode_v[1]),
    .A(a_v[1][1:0]), .B(b_v[1][1:0]), .BUSY(busy_v[1]), .DONE(done_v[1]),
    .S(s1), .COUT(cout_v[1]), .OVF(ovf_v[1]), .dbg_state(st_v[1])
  );

  serial_addsub #(.WIDTH(33)) u_w33 (
    .CLK(CLK), .RST(rst), .START(start_v[2]), .MODE(mode_v[2]),
    .A(a_v[2][32:0]), .B(b_v[2][32:0]), .BUSY(busy_v[2]), .DONE(done_v[2]),
    .S(s2), .COUT(cout_v[2]), .OVF(ovf_v[2]), .dbg_state(st_v[2])
  );

  // Clock and reset signal setup.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] s_of(input int idx);
    case (idx)
      0:       return 64'(s0);
      1:       return 64'(s1);
      default: return 64'(s2);
    endcase
  endfunction

  // Reference: arithmetic on full-width integers, flags from operand signs.
  function automatic logic [65:0] model(input int w, input logic m,
                                        input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] mask;
    logic [64:0] full;
    logic [63:0] r;
    logic        c;
    logic        o;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    av = av & mask;
    bv = bv & mask;
    if (!m) begin
      full = {1'b0, av} + {1'b0, bv};
      r    = full[63:0] & mask;
      c    = full[w];
      o    = (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
    end else begin
      r = (av - bv) & mask;
      c = (av >= bv);
      o = (av[w-1] != bv[w-1]) && (r[w-1] != av[w-1]);
    end
    return {o, c, r};
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input int idx, input int w, input logic m,
                             input logic [63:0] av, input logic [63:0] bv);
    start_v[idx] = 1'b1;
    mode_v[idx]  = m;
    a_v[idx]     = av;
    b_v[idx]     = bv;
    exp_q.push_back(model(w, m, av, bv));
  endtask

  function automatic logic [65:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // One complete operation: latency, BUSY length, result, single DONE.
  task automatic run_op(input int idx, input int w, input logic m,
                        input logic [63:0] av, input logic [63:0] bv, input string tag);
    int lat;
    int bc;
    drive_start(idx, w, m, av, bv);
    @(negedge CLK);
    start_v[idx] = 1'b0;
    mode_v[idx]  = 1'($urandom_range(0, 1));
    a_v[idx]     = {$urandom, $urandom};
    b_v[idx]     = {$urandom, $urandom};
    lat = 1;
    bc  = busy_v[idx] ? 1 : 0;
    while (!done_v[idx] && lat < w + 40) begin
      @(negedge CLK);
      lat++;
      if (busy_v[idx]) bc++;
    end
    check({tag, " latency"}, 66'(lat), 66'(w + 1));
    check({tag, " busy cycles"}, 66'(bc), 66'(w));
    check({tag, " result"}, {ovf_v[idx], cout_v[idx], s_of(idx)}, pop_exp());
    @(negedge CLK);
    check({tag, " done width"}, 66'(done_v[idx]), 66'(0));
  endtask

  // Directed steps, then random regression, then the summary.
  initial begin
    int dcount;
    int d1;
    int d2;
    logic [65:0] held;
    logic [63:0] ra;
    logic [63:0] rb;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    check("reset state", 66'(st_v[0]), 66'(0));
    check("reset outputs", {busy_v[0], done_v[0], cout_v[0], ovf_v[0], s_of(0)}, 68'(0));

    // Basic add with busy/done timing, then hold after FIN.
    run_op(0, 8, 1'b0, 64'h5A, 64'h3C, "add 5a+3c");
    held = {ovf_v[0], cout_v[0], s_of(0)};
    repeat (3) @(negedge CLK);
    check("hold after fin", {ovf_v[0], cout_v[0], s_of(0)}, 66'({1'b1, 1'b0, 64'h96}));
    check("hold vs done", {ovf_v[0], cout_v[0], s_of(0)}, held);

    run_op(0, 8, 1'b0, 64'hFF, 64'h01, "add ff+01");
    run_op(0, 8, 1'b0, 64'h7F, 64'h7F, "add 7f+7f");
    run_op(0, 8, 1'b1, 64'h10, 64'h20, "sub 10-20");
    run_op(0, 8, 1'b1, 64'h80, 64'h01, "sub 80-01");

    // START pulsed mid-RUN must be ignored.
    drive_start(0, 8, 1'b0, 64'h5A, 64'h3C);
    @(negedge CLK);
    dcount = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done_v[0]) begin
        dcount++;
        check("ignore done cycle", 66'(c), 66'(9));
        check("ignore result", {ovf_v[0], cout_v[0], s_of(0)}, pop_exp());
      end
      start_v[0] = (c == 3);
      a_v[0]     = 64'h01;
      b_v[0]     = 64'h01;
      mode_v[0]  = 1'b0;
      @(negedge CLK);
    end
    check("ignore done count", 66'(dcount), 66'(1));

    // Back-to-back: START held through FIN launches the second operation.
    drive_start(0, 8, 1'b0, 64'h12, 64'h34);
    @(negedge CLK);
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 1) begin
        mode_v[0] = 1'b1;
        a_v[0]    = 64'h80;
        b_v[0]    = 64'h01;
        exp_q.push_back(model(8, 1'b1, 64'h80, 64'h01));
      end
      if (c == 10) check("b2b busy reassert", {busy_v[0], done_v[0]}, 66'b10);
      if (done_v[0]) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
        check("b2b result", {ovf_v[0], cout_v[0], s_of(0)}, pop_exp());
      end
      start_v[0] = (c <= 9);
      @(negedge CLK);
    end
    check("b2b first done", 66'(d1), 66'(9));
    check("b2b second done", 66'(d2), 66'(18));

    // Reset during RUN bit 4 discards the operation.
    drive_start(0, 8, 1'b1, 64'h10, 64'h20);
    @(negedge CLK);
    start_v[0] = 1'b0;
    repeat (4) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("mid-run reset outputs", {busy_v[0], done_v[0], cout_v[0], ovf_v[0], s_of(0)}, 68'(0));
    check("mid-run reset state", 66'(st_v[0]), 66'(0));
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      if (done_v[0]) dcount++;
      @(negedge CLK);
    end
    check("no done after reset", 66'(dcount), 66'(0));
    run_op(0, 8, 1'b0, 64'hC3, 64'h5A, "after reset");

    // Random regression across three widths, with corner operands mixed in.
    for (int idx = 0; idx < 3; idx++) begin
      int w;
      int nops;
      w    = (idx == 0) ? 8 : ((idx == 1) ? 2 : 33);
      nops = (idx == 2) ? 120 : 300;
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 5))
          0:       ra = '1;
          1:       ra = '0;
          2:       ra = 64'd1 << (w - 1);
          default: ra = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 5))
          0:       rb = '1;
          1:       rb = '0;
          2:       rb = 64'd1 << (w - 1);
          default: rb = {$urandom, $urandom};
        endcase
        run_op(idx, w, 1'($urandom_range(0, 1)), ra, rb, $sformatf("rand w%0d #%0d", w, k));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
